// File: rtl/uart_reg_bank_param.sv
// uart_reg_bank_param: UART-fed config register bank with shadowed atomic burst commit
// Ports: clk_in/rst_in (sync, active-high); rx_valid_in/rx_data_in decoded bytes from uart_rx;
// regs_out live registers (reg i at [8i+7:8i]); commit_out pulse when regs_out updates;
// frame_err_out pulse on timeout or rejected frame; tx_valid_out/tx_data_out/tx_ready_in
// read-back stream toward uart_tx, present only when REG_BANK_READBACK_EN is defined.
module uart_reg_bank_param #(
  parameter int                    NUM_REGS     = 16,
  parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0,
  parameter int                    TIMEOUT_CLKS = 1636800
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_valid_in,
  input  logic [7:0]            rx_data_in,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  commit_out,
  output logic                  frame_err_out,
  output logic                  tx_valid_out,
  output logic [7:0]            tx_data_out,
  input  logic                  tx_ready_in
);
  localparam int TW = $clog2(TIMEOUT_CLKS);
`ifdef REG_BANK_READBACK_EN
  typedef enum logic [1:0] {IDLE, WDATA, COMMIT, RDATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, WDATA, COMMIT} state_t;
`endif
  state_t                state, nxt;
  logic                  rv;
  logic [7:0]            rd;
  logic [3:0]            addr;
  logic [2:0]            cnt;
  logic [TW-1:0]         tcnt;
  logic [NUM_REGS*8-1:0] live, shadow;
  logic                  busy, expire;
  assign regs_out = live;
`ifdef REG_BANK_READBACK_EN
  logic       tx_valid, hs;
  logic [7:0] tx_data, peek;
  logic [3:0] sel;
  assign busy = state == WDATA || state == RDATA;
  assign hs = tx_valid && tx_ready_in;
  // the first read byte is fetched straight from the header's address field
  assign sel = state == IDLE ? rd[3:0] : addr;
  assign tx_valid_out = tx_valid;
  assign tx_data_out = tx_data;
  always_comb begin
    peek = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) if (sel == 4'(i)) peek = live[i*8+:8];
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready_in;
  assign busy = state == WDATA;
  assign tx_valid_out = 1'b0;
  assign tx_data_out = 8'h00;
`endif
  // a byte in the same cycle as expiry wins over the timeout
  assign expire = busy && !rv && tcnt == TW'(TIMEOUT_CLKS - 1);
  always_comb begin
    nxt = state;
    case (state)
`ifdef REG_BANK_READBACK_EN
      IDLE:   nxt = !rv ? IDLE : rd[7] ? RDATA : WDATA;
      RDATA:  nxt = expire || (hs && cnt == 3'd0) ? IDLE : RDATA;
`else
      IDLE:   nxt = rv && !rd[7] ? WDATA : IDLE;
`endif
      WDATA:  nxt = rv && cnt == 3'd0 ? COMMIT : expire ? IDLE : WDATA;
      COMMIT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) state <= rst_in ? IDLE : nxt;
  // rx bytes pass through one register stage, giving the two-edge commit latency
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rv <= 1'b0;
      rd <= 8'h00;
      addr <= 4'd0;
      cnt <= 3'd0;
      tcnt <= '0;
      live <= RESET_VALUES;
      shadow <= RESET_VALUES;
      commit_out <= 1'b0;
      frame_err_out <= 1'b0;
`ifdef REG_BANK_READBACK_EN
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
`endif
    end else begin
      rv <= rx_valid_in;
      rd <= rx_data_in;
      tcnt <= rv || !busy ? '0 : expire ? tcnt : tcnt + TW'(1);
      commit_out <= state == COMMIT;
`ifdef REG_BANK_READBACK_EN
      frame_err_out <= expire;
`else
      frame_err_out <= expire || (state == IDLE && rv && rd[7]);
`endif
      if (state == IDLE && rv) begin
        addr <= rd[3:0];
        cnt <= rd[6:4];
      end
      if (state == WDATA && rv) begin
        for (int i = 0; i < NUM_REGS; i++) if (addr == 4'(i)) shadow[i*8+:8] <= rd;
        addr <= addr + 4'd1;
        cnt <= cnt - 3'd1;
      end
      if (expire) shadow <= live;
      if (state == COMMIT) live <= shadow;
`ifdef REG_BANK_READBACK_EN
      if (state == IDLE && rv && rd[7]) begin
        tx_valid <= 1'b1;
        tx_data <= peek;
        addr <= rd[3:0] + 4'd1;
      end
      if (state == RDATA && hs) begin
        tx_valid <= cnt != 3'd0;
        if (cnt != 3'd0) tx_data <= peek;
        addr <= addr + 4'd1;
        cnt <= cnt - 3'd1;
      end
      if (expire) tx_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_reg_bank_param.sv
// tb_uart_reg_bank_param: directed vector bench for uart_reg_bank_param
module tb_uart_reg_bank_param;
  localparam int NR = 6;
  localparam int TO = 40;
  localparam logic [47:0] RV = 48'h66_55_44_33_22_11;
`ifdef REG_BANK_READBACK_EN
  localparam int RD_ERR = 0;
`else
  localparam int RD_ERR = 1;
`endif
  typedef struct {
    int          n;
    logic [7:0]  b [9];
    logic [47:0] regs;
    int          commits;
    int          errs;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic [47:0] regs, prev;
  logic        commit, ferr, tx_valid;
  logic [7:0]  tx_data;
  int          n_vec = 0, n_bad = 0, n_commit = 0, n_err = 0, tears = 0;
  vec_t        vecs [7];
  always #5 clk = ~clk;
  uart_reg_bank_param #(.NUM_REGS(NR), .RESET_VALUES(RV), .TIMEOUT_CLKS(TO)) dut (
    .clk_in(clk), .rst_in(rst), .rx_valid_in(rx_valid), .rx_data_in(rx_data),
    .regs_out(regs), .commit_out(commit), .frame_err_out(ferr),
    .tx_valid_out(tx_valid), .tx_data_out(tx_data), .tx_ready_in(tx_ready)
  );
  always @(negedge clk) begin
    if (commit) n_commit++;
    if (ferr) n_err++;
    if (!rst && regs !== prev && !commit) tears++;
    prev = regs;
  end
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap = 2);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    int c0, e0, held_bad;
    logic [7:0] q[$];
    vecs[0] = '{2, '{8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 48'hCD_AB_44_33_22_07, 1, 0};
    vecs[1] = '{5, '{8'h31, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00}, 48'hCD_A4_A3_A2_A1_07, 1, 0};
    vecs[2] = '{1, '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 48'hCD_A4_A3_A2_A1_07, 0, RD_ERR};
    vecs[3] = '{9, '{8'h72, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 48'h04_03_02_01_A1_07, 1, 0};
    vecs[4] = '{2, '{8'h0F, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 48'h04_03_02_01_A1_07, 1, 0};
    vecs[5] = '{3, '{8'h1F, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 48'h04_03_02_01_A1_66, 1, 0};
    vecs[6] = '{5, '{8'h35, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, 48'h11_03_02_01_A1_66, 1, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_regs", regs, RV);
    chk("reset_commit", commit, 0);
    chk("reset_err", ferr, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    c0 = n_commit;
    send(8'h14);
    send(8'hAB);
    send(8'hCD, 0);
    @(negedge clk);
    chk("latency_e1_regs", regs, RV);
    chk("latency_e1_commit", commit, 0);
    @(negedge clk);
    chk("latency_e2_regs", regs, 48'hCD_AB_44_33_22_11);
    chk("latency_e2_commit", commit, 1);
    repeat (6) @(negedge clk);
    chk("latency_commit_count", n_commit - c0, 1);
    for (int v = 0; v < 7; v++) begin
      c0 = n_commit;
      e0 = n_err;
      for (int k = 0; k < vecs[v].n; k++) send(vecs[v].b[k]);
      repeat (12) @(negedge clk);
      chk($sformatf("vec%0d_regs", v), regs, vecs[v].regs);
      chk($sformatf("vec%0d_commits", v), n_commit - c0, vecs[v].commits);
      chk($sformatf("vec%0d_errs", v), n_err - e0, vecs[v].errs);
    end
    c0 = n_commit;
    e0 = n_err;
    send(8'h20);
    send(8'h01, 0);
    repeat (34) @(negedge clk);
    chk("timeout_early", n_err - e0, 0);
    repeat (16) @(negedge clk);
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_regs", regs, 48'h11_03_02_01_A1_66);
    chk("timeout_commits", n_commit - c0, 0);
    c0 = n_commit;
    send(8'h00);
    send(8'h07);
    repeat (10) @(negedge clk);
    chk("after_timeout_regs", regs, 48'h11_03_02_01_A1_07);
    chk("after_timeout_commit", n_commit - c0, 1);
    send(8'h22);
    send(8'hEE);
    rst = 1'b1;
    c0 = n_commit;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midreset_regs", regs, RV);
    chk("midreset_commits", n_commit - c0, 0);
    c0 = n_commit;
    send(8'h01);
    send(8'h5C);
    repeat (10) @(negedge clk);
    chk("post_reset_regs", regs, 48'h66_55_44_33_5C_11);
    chk("post_reset_commit", n_commit - c0, 1);
`ifdef REG_BANK_READBACK_EN
    send(8'h12);
    send(8'h5A);
    send(8'hA5);
    repeat (10) @(negedge clk);
    chk("rb_write_regs", regs, 48'h66_55_A5_5A_5C_11);
    tx_ready = 1'b0;
    send(8'h92, 0);
    held_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h5A)) held_bad++;
    end
    chk("rb_hold_cycles_bad", held_bad, 0);
    tx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (tx_valid && tx_ready) q.push_back(tx_data);
      @(negedge clk);
    end
    chk("rb_count", q.size(), 2);
    chk("rb_byte0", q.size() > 0 ? q[0] : 8'hxx, 8'h5A);
    chk("rb_byte1", q.size() > 1 ? q[1] : 8'hxx, 8'hA5);
    chk("rb_valid_low", tx_valid, 0);
`endif
    chk("no_tear", tears, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
